// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between the to_host MMIO write path and UARTTX.
// Buffers pushed bytes and drains them one at a time over DATA/WE/READY.
//
// Ports:
//   CLK, RST_X          clock, async active-low reset
//   WE, DATA, FLUSH     push request, pushed byte, synchronous clear
//   FULL, EMPTY, COUNT  occupancy status, decoded from the count register
//   DROPPED             saturating count of pushes rejected while full
//   TX_DATA, TX_WE      byte and one-cycle strobe to UARTTX
//   TX_READY            UARTTX ready
module uart_tx_buffer #(
    parameter int DEPTH_LOG = 4,
    parameter int GUARD     = 2
) (
    input  logic                 CLK,
    input  logic                 RST_X,
    input  logic                 WE,
    input  logic [7:0]           DATA,
    input  logic                 FLUSH,
    output logic                 FULL,
    output logic                 EMPTY,
    output logic [DEPTH_LOG:0]   COUNT,
    output logic [15:0]          DROPPED,
    output logic [7:0]           TX_DATA,
    output logic                 TX_WE,
    input  logic                 TX_READY
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam int GW    = (GUARD > 1) ? $clog2(GUARD) : 1;

    localparam logic [DEPTH_LOG:0] CNT_FULL = {1'b1, {DEPTH_LOG{1'b0}}};
    localparam logic [GW-1:0]      GUARD_INIT = GW'(GUARD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [7:0]           mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [15:0]          dropped_q, dropped_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [GW-1:0]        guard_q, guard_d;

    logic full;
    logic empty;
    logic push;
    logic drop;
    logic pop;

    // Full is judged on the pre-edge count, so a pop in the same
    // cycle does not make room for a push.
    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);
    assign push  = WE && !full && !FLUSH;
    assign drop  = WE && full && !FLUSH;
    assign pop   = (state_q == S_IDLE) && !empty && TX_READY && !FLUSH;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = dropped_q;
        if (FLUSH) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (drop && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    // Drain FSM. HOLD masks TX_READY for GUARD cycles so the
    // registered READY fall inside UARTTX is not mistaken for idle.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                guard_d = GUARD_INIT;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (guard_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
            tx_data_q <= '0;
            guard_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
            tx_data_q <= tx_data_d;
            guard_q   <= guard_d;
        end
    end

    // Storage needs no reset: reads are gated by the count.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= DATA;
        end
    end

    assign FULL    = full;
    assign EMPTY   = empty;
    assign COUNT   = count_q;
    assign DROPPED = dropped_q;
    assign TX_DATA = tx_data_q;
    assign TX_WE   = (state_q == S_SEND);

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed bench for uart_tx_buffer with a queue
// model of the FIFO/drain behaviour and a simple UARTTX peer.
module tb_uart_tx_buffer;

    localparam int DL    = 4;
    localparam int GUARD = 2;
    localparam int DEPTH = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        we        = 1'b0;
    logic        flush     = 1'b0;
    logic [7:0]  data      = 8'h00;
    logic        man_rdy   = 1'b1;
    logic        uart_auto = 1'b0;
    logic        uart_rdy  = 1'b1;
    logic        tx_ready;

    logic        full;
    logic        empty;
    logic [DL:0] count;
    logic [15:0] dropped;
    logic [7:0]  tx_data;
    logic        tx_we;

    int n_chk  = 0;
    int n_fail = 0;

    int         busy   = 0;
    int         bt     = 6;
    int         we_cnt = 0;
    logic [7:0] rx[$];

    logic [7:0] mq[$];
    int         m_drop = 0;
    logic       m_we   = 1'b0;
    logic [7:0] m_data = 8'h00;
    int         since  = GUARD + 2;
    bit         was_full;

    assign tx_ready = uart_auto ? uart_rdy : man_rdy;

    uart_tx_buffer #(.DEPTH_LOG(DL), .GUARD(GUARD)) dut (
        .CLK      (clk),
        .RST_X    (rst_n),
        .WE       (we),
        .DATA     (data),
        .FLUSH    (flush),
        .FULL     (full),
        .EMPTY    (empty),
        .COUNT    (count),
        .DROPPED  (dropped),
        .TX_DATA  (tx_data),
        .TX_WE    (tx_we),
        .TX_READY (tx_ready)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: a byte queue; a pop needs a non-empty queue, READY and
    // at least GUARD+2 edges since the previous pop.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
            m_we   = 1'b0;
            m_data = 8'h00;
            since  = GUARD + 2;
        end else begin
            was_full = (mq.size() == DEPTH);
            if (since < 1000) since++;
            m_we = 1'b0;
            if (!flush && tx_ready && mq.size() != 0 &&
                since >= GUARD + 2) begin
                m_data = mq.pop_front();
                m_we   = 1'b1;
                since  = 0;
            end
            if (flush) begin
                mq.delete();
            end else if (we) begin
                if (was_full) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    mq.push_back(data);
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("count",   32'(count),   32'(mq.size()));
            chk("empty",   32'(empty),   32'(mq.size() == 0));
            chk("full",    32'(full),    32'(mq.size() == DEPTH));
            chk("dropped", 32'(dropped), 32'(m_drop));
            chk("tx_we",   32'(tx_we),   32'(m_we));
            chk("tx_data", 32'(tx_data), 32'(m_data));
        end
    end

    // UARTTX peer: READY drops on WE and returns after bt cycles.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            busy     = 0;
            uart_rdy = 1'b1;
        end else if (tx_we) begin
            rx.push_back(tx_data);
            we_cnt++;
            busy     = bt;
            uart_rdy = 1'b0;
        end else begin
            if (busy > 0) busy--;
            uart_rdy = (busy == 0);
        end
    end

    task automatic push(input logic [7:0] b);
        we   = 1'b1;
        data = b;
        @(negedge clk);
        we   = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        uart_auto = 1'b1;
        while ((count != 0 || !uart_rdy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_drain_done"}, 32'(n < 2000), 32'd1);
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int w0;
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        #1;
        chk("rst_tx_we",   32'(tx_we),   32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_count",   32'(count),   32'd0);
        chk("rst_empty",   32'(empty),   32'd1);
        chk("rst_full",    32'(full),    32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte latency.
        man_rdy = 1'b1;
        push(8'h41);
        chk("t1_count1", 32'(count), 32'd1);
        chk("t1_we0",    32'(tx_we), 32'd0);
        @(negedge clk);
        chk("t1_we1",    32'(tx_we),   32'd1);
        chk("t1_data",   32'(tx_data), 32'h41);
        chk("t1_count0", 32'(count),   32'd0);
        @(negedge clk);
        chk("t1_we_end", 32'(tx_we), 32'd0);
        repeat (8) @(negedge clk);

        // Overflow with READY low, then ordered drain.
        man_rdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            push(8'(i));
            if (i == 15) begin
                chk("t2_full16",  32'(full),  32'd1);
                chk("t2_count16", 32'(count), 32'd16);
            end
        end
        chk("t2_dropped", 32'(dropped), 32'd4);
        rx.delete();
        drain("t2");
        chk("t2_rx_n", 32'(rx.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx.size(); i++)
            chk("t2_rx", 32'(rx[i]), 32'(i));

        // Push on a full FIFO in the same cycle as a pop.
        uart_auto = 1'b0;
        man_rdy   = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
        chk("t3_count16", 32'(count), 32'd16);
        man_rdy = 1'b1;
        we      = 1'b1;
        data    = 8'hAA;
        @(negedge clk);
        we      = 1'b0;
        man_rdy = 1'b0;
        chk("t3_dropped", 32'(dropped), 32'd5);
        chk("t3_count15", 32'(count),   32'd15);
        chk("t3_we",      32'(tx_we),   32'd1);
        chk("t3_data",    32'(tx_data), 32'h60);
        drain("t3");

        // Reset in HOLD with three bytes queued.
        uart_auto = 1'b0;
        man_rdy   = 1'b0;
        for (int i = 0; i < 4; i++) push(8'(8'h30 + i));
        man_rdy = 1'b1;
        @(negedge clk);
        chk("t6_we", 32'(tx_we), 32'd1);
        @(negedge clk);
        chk("t6_count3", 32'(count), 32'd3);
        #2;
        rst_n   = 1'b0;
        man_rdy = 1'b0;
        #1;
        chk("t6_tx_we",   32'(tx_we),   32'd0);
        chk("t6_tx_data", 32'(tx_data), 32'd0);
        chk("t6_count",   32'(count),   32'd0);
        chk("t6_empty",   32'(empty),   32'd1);
        chk("t6_full",    32'(full),    32'd0);
        chk("t6_dropped", 32'(dropped), 32'd0);
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        man_rdy = 1'b1;
        #1;
        w0 = we_cnt;
        repeat (20) @(negedge clk);
        #1;
        chk("t6_no_we", 32'(we_cnt - w0), 32'd0);

        // Pointer wrap: 40 bytes at a sustainable rate.
        rx.delete();
        uart_auto = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push(8'(8'h80 + i));
            repeat (9) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("t4_rx_n", 32'(rx.size()), 32'd40);
        for (int i = 0; i < 40 && i < rx.size(); i++)
            chk("t4_rx", 32'(rx[i]), 32'(8'h80 + i));
        chk("t4_dropped", 32'(dropped), 32'd0);

        // FLUSH with a simultaneous push while in HOLD.
        uart_auto = 1'b0;
        man_rdy   = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        man_rdy = 1'b1;
        @(negedge clk);
        chk("t5_we",   32'(tx_we),   32'd1);
        chk("t5_data", 32'(tx_data), 32'h50);
        @(negedge clk);
        flush = 1'b1;
        we    = 1'b1;
        data  = 8'h7E;
        @(negedge clk);
        flush = 1'b0;
        we    = 1'b0;
        chk("t5_count",   32'(count),   32'd0);
        chk("t5_empty",   32'(empty),   32'd1);
        chk("t5_dropped", 32'(dropped), 32'd0);
        #1;
        w0 = we_cnt;
        repeat (15) @(negedge clk);
        #1;
        chk("t5_no_we", 32'(we_cnt - w0), 32'd0);
        chk("t5_last",  32'(rx[$]),       32'h50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
